// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the processor/ROM fetch path: FSM encodings, requester IDs, default widths.
// Imported by rom_arbiter and rom_arb_pick.
package rom_arbiter_pkg;

    localparam int ROM_ADDR_W_DEF = 16;
    localparam int ROM_DATA_W_DEF = 28;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } arb_state_t;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    function automatic logic other_id(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/rom_arb_pick.sv
// Two-way priority pick: requests (+ round-robin pointer) -> one-hot grant, purely combinational.
// Build option ROM_ARB_FIXED_PRIO_EN: requester 0 always wins and the pointer input is removed.
module rom_arb_pick
    import rom_arbiter_pkg::*;
(
    input  logic [1:0] req,
`ifndef ROM_ARB_FIXED_PRIO_EN
    input  logic       ptr,
`endif
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
            gnt[REQ_ID0] = 1'b1;
`else
            gnt = (ptr == REQ_ID1) ? 2'b10 : 2'b01;
`endif
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates two fetch requesters onto one combinational ROM; IDLE grants, FETCH captures, 2-cycle latency.
// Build option ROM_ARB_FIXED_PRIO_EN selects fixed priority (requester 0) instead of round-robin.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W_DEF,
    parameter int DATA_W = ROM_DATA_W_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iReq0,
    input  logic              iReq1,
    input  logic [ADDR_W-1:0] iAddr0,
    input  logic [ADDR_W-1:0] iAddr1,
    output logic              oGnt0,
    output logic              oGnt1,
    output logic              oValid0,
    output logic              oValid1,
    output logic [ADDR_W-1:0] oRomAddress,
    input  logic [DATA_W-1:0] iRomInstruction,
    output logic [DATA_W-1:0] oInstruction
);

    arb_state_t        state;
    logic              winner;
    logic [1:0]        pick;
    logic [1:0]        grant;
    logic [1:0]        valid;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] instr;

`ifdef ROM_ARB_FIXED_PRIO_EN
    rom_arb_pick u_pick (
        .req ({iReq1, iReq0}),
        .gnt (pick)
    );
`else
    logic ptr;

    rom_arb_pick u_pick (
        .req ({iReq1, iReq0}),
        .ptr (ptr),
        .gnt (pick)
    );
`endif

    // Grants only exist in IDLE; gating with Reset keeps them low while held in reset.
    always_comb begin
        grant = 2'b00;
        if (state == ST_IDLE && Reset) begin
            grant = pick;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            winner   <= REQ_ID0;
            rom_addr <= '0;
            instr    <= '0;
            valid    <= 2'b00;
`ifndef ROM_ARB_FIXED_PRIO_EN
            ptr      <= REQ_ID0;
`endif
        end else begin
            valid <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        rom_addr <= grant[REQ_ID1] ? iAddr1 : iAddr0;
                        winner   <= grant[REQ_ID1];
`ifndef ROM_ARB_FIXED_PRIO_EN
                        ptr      <= other_id(grant[REQ_ID1]);
`endif
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    instr <= iRomInstruction;
                    valid <= (winner == REQ_ID1) ? 2'b10 : 2'b01;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign oGnt0        = grant[REQ_ID0];
    assign oGnt1        = grant[REQ_ID1];
    assign oValid0      = valid[REQ_ID0];
    assign oValid1      = valid[REQ_ID1];
    assign oRomAddress  = rom_addr;
    assign oInstruction = instr;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a ROM model returning 28'hA000000 | address.
// Build option ROM_ARB_FIXED_PRIO_EN changes the expected grant order in the contention run.
module tb_rom_arbiter;

    localparam int AW = 16;
    localparam int DW = 28;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          iReq0 = 1'b0;
    logic          iReq1 = 1'b0;
    logic [AW-1:0] iAddr0 = '0;
    logic [AW-1:0] iAddr1 = '0;
    logic          oGnt0, oGnt1, oValid0, oValid1;
    logic [AW-1:0] oRomAddress;
    logic [DW-1:0] iRomInstruction;
    logic [DW-1:0] oInstruction;

    int compared   = 0;
    int mismatched = 0;

    always #5 Clock = ~Clock;

    assign iRomInstruction = 28'hA000000 | {{(DW-AW){1'b0}}, oRomAddress};

    rom_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .iReq0           (iReq0),
        .iReq1           (iReq1),
        .iAddr0          (iAddr0),
        .iAddr1          (iAddr1),
        .oGnt0           (oGnt0),
        .oGnt1           (oGnt1),
        .oValid0         (oValid0),
        .oValid1         (oValid1),
        .oRomAddress     (oRomAddress),
        .iRomInstruction (iRomInstruction),
        .oInstruction    (oInstruction)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic r0, input logic [AW-1:0] a0,
                         input logic r1, input logic [AW-1:0] a1);
        @(negedge Clock);
        iReq0  = r0;
        iAddr0 = a0;
        iReq1  = r1;
        iAddr1 = a1;
        #1;
    endtask

    task automatic check_gv(input string tag, input logic g0, input logic g1,
                            input logic v0, input logic v1);
        check({tag, "_gnt"},   {30'd0, oGnt1, oGnt0},     {30'd0, g1, g0});
        check({tag, "_valid"}, {30'd0, oValid1, oValid0}, {30'd0, v1, v0});
    endtask

    logic exp_win;
    logic prev_win;

    initial begin
        // Held in reset with a pending request: everything must stay quiet.
        drive(1'b1, 16'd5, 1'b0, 16'd0);
        check_gv("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_addr",  {16'd0, oRomAddress}, 32'd0);
        check("rst_instr", {4'd0, oInstruction}, 32'd0);
        drive(1'b1, 16'd5, 1'b0, 16'd0);
        check_gv("rst2", 1'b0, 1'b0, 1'b0, 1'b0);

        // Single fetch from requester 0 at address 5, granted in the first cycle after release.
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        check_gv("single_hs", 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'd0, 1'b0, 16'd0);
        check_gv("single_fetch", 1'b0, 1'b0, 1'b0, 1'b0);
        check("single_addr", {16'd0, oRomAddress}, 32'd5);
        drive(1'b0, 16'd0, 1'b0, 16'd0);
        check_gv("single_valid", 1'b0, 1'b0, 1'b1, 1'b0);
        check("single_instr", {4'd0, oInstruction}, 32'h0A000005);
        drive(1'b0, 16'd0, 1'b0, 16'd0);
        check_gv("single_after", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset pulse, then simultaneous requests: 3 to requester 0 first, then 9 to requester 1.
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        drive(1'b1, 16'd3, 1'b1, 16'd9);
        check_gv("both_c1", 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'd0, 1'b1, 16'd9);
        check_gv("both_c2", 1'b0, 1'b0, 1'b0, 1'b0);
        check("both_addr3", {16'd0, oRomAddress}, 32'd3);
        drive(1'b0, 16'd0, 1'b1, 16'd9);
        check_gv("both_c3", 1'b0, 1'b1, 1'b1, 1'b0);
        check("both_instr3", {4'd0, oInstruction}, 32'h0A000003);
        drive(1'b0, 16'd0, 1'b0, 16'd0);
        check_gv("both_c4", 1'b0, 1'b0, 1'b0, 1'b0);
        check("both_addr9", {16'd0, oRomAddress}, 32'd9);
        drive(1'b0, 16'd0, 1'b0, 16'd0);
        check_gv("both_c5", 1'b0, 1'b0, 1'b0, 1'b1);
        check("both_instr9", {4'd0, oInstruction}, 32'h0A000009);

        // Continuous contention for 8 fetches; the pointer starts at requester 0 here.
        prev_win = 1'b0;
        for (int i = 0; i < 8; i++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
            exp_win = 1'b0;
`else
            exp_win = i[0];
`endif
            drive(1'b1, 16'h0010, 1'b1, 16'h0020);
            if (i == 0) begin
                check_gv($sformatf("rr%0d_idle", i), ~exp_win, exp_win, 1'b0, 1'b0);
            end else begin
                check_gv($sformatf("rr%0d_idle", i), ~exp_win, exp_win, ~prev_win, prev_win);
            end
            drive(1'b1, 16'h0010, 1'b1, 16'h0020);
            check_gv($sformatf("rr%0d_fetch", i), 1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("rr%0d_addr", i), {16'd0, oRomAddress},
                  exp_win ? 32'h20 : 32'h10);
            prev_win = exp_win;
        end
        drive(1'b0, 16'd0, 1'b0, 16'd0);
        check_gv("rr_last_valid", 1'b0, 1'b0, ~prev_win, prev_win);
        check("rr_last_instr", {4'd0, oInstruction}, prev_win ? 32'h0A000020 : 32'h0A000010);

        // Reset asserted mid-fetch of address 7 aborts it without a valid pulse.
        drive(1'b1, 16'd7, 1'b0, 16'd0);
        check_gv("abort_hs", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge Clock);
        iReq0 = 1'b0;
        Reset = 1'b0;
        #1;
        check_gv("abort_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check("abort_addr",  {16'd0, oRomAddress}, 32'd0);
        check("abort_instr", {4'd0, oInstruction}, 32'd0);
        drive(1'b0, 16'd0, 1'b0, 16'd0);
        check_gv("abort_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge Clock);
        Reset  = 1'b1;
        iReq0  = 1'b1;
        iAddr0 = 16'd7;
        #1;
        check_gv("abort_regrant", 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 16'd0, 1'b0, 16'd0);
        check("abort_addr7", {16'd0, oRomAddress}, 32'd7);
        drive(1'b0, 16'd0, 1'b0, 16'd0);
        check_gv("abort_valid", 1'b0, 1'b0, 1'b1, 1'b0);
        check("abort_instr7", {4'd0, oInstruction}, 32'h0A000007);

        // Requester 1 drops its request right after the handshake at the top address.
        drive(1'b0, 16'd0, 1'b1, 16'hFFFF);
        check_gv("drop_hs", 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 16'd0, 1'b0, 16'd0);
        check_gv("drop_fetch", 1'b0, 1'b0, 1'b0, 1'b0);
        check("drop_addr", {16'd0, oRomAddress}, 32'h0000FFFF);
        drive(1'b0, 16'd0, 1'b0, 16'd0);
        check_gv("drop_valid", 1'b0, 1'b0, 1'b0, 1'b1);
        check("drop_instr", {4'd0, oInstruction}, 32'h0A00FFFF);

        // Ten idle cycles: nothing granted or valid, the last word is held.
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 16'd0, 1'b0, 16'd0);
            check_gv($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("idle%0d_instr", i), {4'd0, oInstruction}, 32'h0A00FFFF);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the ROM address width.
REQ-002 Parameter DATA_W, default 28, SHALL set the instruction word width.
REQ-003 Clock  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 iReq0 / iReq1  input  1 each  SHALL carry the requester 0 / requester 1 fetch request, held until grant.
REQ-006 iAddr0 / iAddr1  input  ADDR_W each  SHALL carry the requested ROM address, stable while iReqN is high.
REQ-007 oGnt0 / oGnt1  output  1 each  SHALL be the combinational grant; iReqN&oGntN at a rising edge completes the address handshake.
REQ-008 oValid0 / oValid1  output  1 each  SHALL be a registered one-cycle pulse marking oInstruction valid for that requester.
REQ-009 oRomAddress  output  ADDR_W  SHALL be the registered address driving the shared combinational ROM.
REQ-010 iRomInstruction  input  DATA_W  SHALL be the ROM data for oRomAddress.
REQ-011 oInstruction  output  DATA_W  SHALL be the registered fetched word, shared by both requesters.

Function
REQ-012 FSM states SHALL be IDLE and FETCH only.
REQ-013 In IDLE with at least one iReqN high, exactly one oGntN SHALL be asserted; with no request, both grants SHALL be low.
REQ-014 At the edge ending a granted IDLE cycle: oRomAddress <= iAddrN of the winner, winner ID registered, state -> FETCH.
REQ-015 In FETCH both grants SHALL be low; at the edge ending FETCH: oInstruction <= iRomInstruction, oValidN <= 1 for the stored winner, state -> IDLE.
REQ-016 Latency: handshake edge E -> oValidN high in the cycle after edge E+1 (two cycles); sustained throughput one fetch per two cycles.
REQ-017 oValidN SHALL be high for exactly one cycle per completed handshake; oValid0 and oValid1 SHALL never be high together.
REQ-018 A new grant MAY be issued in the same IDLE cycle that oValidN is high.
REQ-019 Round-robin: a one-bit pointer SHALL name the preferred requester; on a simultaneous request the preferred one wins, and the pointer SHALL flip to the other requester after every handshake.
REQ-020 A single requester SHALL be granted regardless of pointer value.
REQ-021 A requester deasserting iReqN after its handshake SHALL still receive its oValidN pulse; the requester SHALL NOT be re-granted for that request.
REQ-022 oInstruction SHALL hold its last value between captures.

Reset
REQ-023 While Reset is low, the block SHALL hold state IDLE, pointer = requester 0, oRomAddress = 0, oInstruction = 0, oValid0 = oValid1 = 0, and both grants SHALL be low.
REQ-024 Reset asserted during FETCH SHALL abort the fetch with no oValid pulse; first grant possible in the first cycle after release.

Configuration
REQ-025 Macro ROM_ARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win simultaneous requests and the pointer SHALL be absent; when undefined, REQ-019 round-robin SHALL apply.

Structure
REQ-026 FSM state encodings, requester ID constants and the ADDR_W/DATA_W defaults SHALL live in the shared definitions include used by the processor and ROM.
REQ-027 The priority pick (requests + pointer -> one-hot grant) SHALL be the one sub-module, rom_arb_pick; everything else SHALL be in rom_arbiter.

Verification
Bench ROM model: word = 28'hA000000 | address.
REQ-028 iReq0=1, iAddr0=5, iReq1=0 -> oGnt0 high in that cycle; oRomAddress=5 next cycle; two cycles after the handshake, oValid0 is pulsed and oInstruction=28'hA000005.
REQ-029 After reset, both requesting, iAddr0=3, iAddr1=9 -> fetch order is 3 (to requester 0), then 9 (to requester 1); one oValid pulse each, four cycles total.
REQ-030 Both requesters hold requests continuously for 8 fetches -> grants strictly alternate 0,1,0,1,...; with ROM_ARB_FIXED_PRIO_EN defined -> all 8 grants go to requester 0.
REQ-031 Reset pulled low during FETCH for address 7 -> no oValid; oInstruction=0, oRomAddress=0; after release the first request completes normally.
REQ-032 Requester 1 drops iReq1 the cycle after its handshake at address 16'hFFFF -> oValid1 still pulses with oInstruction=28'hA00FFFF, and there is no second grant.
REQ-033 No requests for 10 cycles -> grants and valids stay 0, and oInstruction holds its previous value.
